// File: rtl/decoder_pkg.sv
// Shared types for the scanning one-hot decoder: operating modes and FSM states.
package decoder_pkg;

  typedef enum logic [1:0] {
    DIRECT    = 2'b00,
    SCAN_UP   = 2'b01,
    SCAN_DOWN = 2'b10,
    HOLD      = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Down-counting dwell timer: holds each scan line for dwell+1 clocks; expire marks the last clock.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               reload,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] timer_q, timer_d;

  // Clear beats reload beats hold; a zero count rests until reloaded.
  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (reload) begin
      timer_d = dwell;
    end else if (!hold && (timer_q != '0)) begin
      timer_d = timer_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expire = (timer_q == '0);

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with direct select, timed up/down auto-scan and hold.
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EN,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      in,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  active,
  output logic                  wrap
);

  localparam int unsigned NOUT = 2 ** SEL_W;

  state_e state_q, state_d;
  mode_e  mode_in, mode_q;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [NOUT-1:0]  out_q, out_d;
  logic             active_q, active_d;
  logic             wrap_q, wrap_d;

  logic t_clear, t_reload, t_hold, t_expire;
  logic mode_switch;

  assign mode_in = mode_e'(mode);

  dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (t_clear),
    .reload(t_reload),
    .hold  (t_hold),
    .dwell (dwell),
    .expire(t_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = EN ? RUN : IDLE;
  end

  // Entering a scan from DIRECT or the opposite scan restarts the dwell; leaving HOLD does not.
  assign mode_switch = (mode_q != mode_in) && (mode_q != HOLD);

  // Output / datapath logic
  always_comb begin
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    active_d = 1'b0;
    t_clear  = 1'b0;
    t_reload = 1'b0;
    t_hold   = 1'b0;
    if (state_d == IDLE) begin
      t_clear = 1'b1;
    end else if (state_q == IDLE) begin
      active_d = 1'b1;
      idx_d    = in;
      t_hold   = (mode_in == HOLD);
      t_reload = (mode_in != HOLD);
    end else begin
      active_d = 1'b1;
      unique case (mode_in)
        DIRECT: begin
          idx_d    = in;
          t_reload = 1'b1;
        end
        SCAN_UP, SCAN_DOWN: begin
          if (load) begin
            idx_d    = in;
            t_reload = 1'b1;
          end else if (mode_switch) begin
            t_reload = 1'b1;
          end else if (t_expire) begin
            t_reload = 1'b1;
            if (mode_in == SCAN_UP) begin
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == '1);
            end else begin
              idx_d  = idx_q - SEL_W'(1);
              wrap_d = (idx_q == '0);
            end
          end
        end
        HOLD: begin
          t_hold = 1'b1;
        end
      endcase
    end
  end

  // Encode from the next index so out and idx change on the same edge.
  always_comb begin
    out_d = '0;
    if (active_d) begin
      out_d = NOUT'(1) << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      out_q    <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= DIRECT;
    end else begin
      idx_q    <= idx_d;
      out_q    <= out_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
      if (EN) begin
        mode_q <= mode_in;
      end
    end
  end

  assign out    = out_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Directed bench for decoder_scan_nto2n (SEL_W=3, DWELL_W=8) with a short random invariant soak.
module tb_decoder_scan_nto2n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       EN;
  logic [1:0] mode;
  logic [2:0] in;
  logic       load;
  logic [7:0] dwell;
  logic [7:0] out;
  logic [2:0] idx;
  logic       active;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan_nto2n #(
    .SEL_W  (3),
    .DWELL_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .EN    (EN),
    .mode  (mode),
    .in    (in),
    .load  (load),
    .dwell (dwell),
    .out   (out),
    .idx   (idx),
    .active(active),
    .wrap  (wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic [2:0] e_idx,
                         input logic e_act, input logic e_wrap);
    chk({tag, ".out"}, 64'(out), 64'(e_out));
    chk({tag, ".idx"}, 64'(idx), 64'(e_idx));
    chk({tag, ".active"}, 64'(active), 64'(e_act));
    chk({tag, ".wrap"}, 64'(wrap), 64'(e_wrap));
  endtask

  logic [7:0] direct_out [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] up_out     [10] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80,
                                  8'h01, 8'h01, 8'h01, 8'h02};
  logic [2:0] up_idx     [10] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
  logic       up_wrap    [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    EN    = 1'b1;
    mode  = 2'b00;
    in    = 3'd5;
    load  = 1'b0;
    dwell = 8'd0;

    // Reset dominates EN=1
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    chk_all("release", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk_all("first_run", 8'h20, 3'd5, 1'b1, 1'b0);

    // DIRECT sweep
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      step();
      chk_all("direct", direct_out[i], 3'(i), 1'b1, 1'b0);
    end
    EN = 1'b0;
    step();
    chk_all("direct_off", 8'h00, 3'd7, 1'b0, 1'b0);

    // SCAN_UP from 6 with dwell 2
    EN    = 1'b1;
    mode  = 2'b01;
    in    = 3'd6;
    dwell = 8'd2;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("scan_up", up_out[i], up_idx[i], 1'b1, up_wrap[i]);
    end

    // SCAN_DOWN dwell 0, loaded at 1
    mode  = 2'b10;
    dwell = 8'd0;
    in    = 3'd1;
    load  = 1'b1;
    step();
    chk_all("dn_load", 8'h02, 3'd1, 1'b1, 1'b0);
    load = 1'b0;
    step();
    chk_all("dn_0", 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    chk_all("dn_wrap", 8'h80, 3'd7, 1'b1, 1'b1);
    step();
    chk_all("dn_6", 8'h40, 3'd6, 1'b1, 1'b0);

    // Direction change reloads dwell=3, then HOLD mid-dwell
    mode  = 2'b01;
    dwell = 8'd3;
    step();
    chk_all("up_switch", 8'h40, 3'd6, 1'b1, 1'b0);
    step();
    step();
    chk_all("up_mid", 8'h40, 3'd6, 1'b1, 1'b0);
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("hold", 8'h40, 3'd6, 1'b1, 1'b0);
    end
    mode = 2'b01;
    step();
    chk_all("resume_rem", 8'h40, 3'd6, 1'b1, 1'b0);
    step();
    chk_all("resume_step", 8'h80, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("dwell7", 8'h80, 3'd7, 1'b1, 1'b0);
    end
    // Timer at zero on idx 7: load must beat the wrapping step
    load = 1'b1;
    in   = 3'd3;
    step();
    chk_all("load_beats_step", 8'h08, 3'd3, 1'b1, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("dwell3", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step();
    chk_all("at4", 8'h10, 3'd4, 1'b1, 1'b0);

    // EN drop mid-scan and restart at in=2
    EN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("en_off", 8'h00, 3'd4, 1'b0, 1'b0);
    end
    EN = 1'b1;
    in = 3'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("restart", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step();
    chk_all("restart_step", 8'h08, 3'd3, 1'b1, 1'b0);

    // DIRECT -> SCAN keeps idx, SCAN -> DIRECT takes in immediately
    mode = 2'b00;
    in   = 3'd5;
    step();
    chk_all("to_direct", 8'h20, 3'd5, 1'b1, 1'b0);
    mode  = 2'b01;
    dwell = 8'd1;
    in    = 3'd0;
    step();
    chk_all("d2s_0", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    chk_all("d2s_1", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    chk_all("d2s_step", 8'h40, 3'd6, 1'b1, 1'b0);
    mode = 2'b00;
    in   = 3'd1;
    step();
    chk_all("s2d", 8'h02, 3'd1, 1'b1, 1'b0);

    // Random soak: one-hot / active / wrap invariants
    for (int i = 0; i < 300; i++) begin
      EN    = ($urandom_range(0, 9) != 0);
      mode  = 2'($urandom_range(0, 3));
      in    = 3'($urandom_range(0, 7));
      load  = ($urandom_range(0, 7) == 0);
      dwell = 8'($urandom_range(0, 3));
      step();
      chk("soak.onehot", 64'($countones(out) <= 1), 64'd1);
      chk("soak.active", 64'(active), 64'(|out));
      chk("soak.wrap_active", 64'(!wrap || active), 64'd1);
      if (active) begin
        chk("soak.out_idx", 64'(out), 64'(8'h01 << idx));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
